mult_issue: RTL and testbench
=============================

Name: mult_issue

Overview:
- Upstream front-end for the n-bit shift-add multiplier (sequencer plus datapath).
- Accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry queue.
- Drives the sequencer's start and the datapath operand buses, captures the 2N-bit product when the sequencer reports ready, and presents it downstream over a valid/ready handshake.
- Handles the start protocol: start is held through the whole multiply, then dropped for at least one cycle so the sequencer returns to idle.

Parameters:
- N, 8, operand width in bits. The product is 2*N bits.
- DEPTH, 2, operand queue entries. Must be a power of 2, at least 2.
- TIMEOUT, 64, watchdog limit in cycles. Used only when ISSUE_TIMEOUT_EN is defined.

Ports:
- clock, input, 1, system clock, rising edge.
- nreset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand pair offered.
- in_ready, output, 1, queue can accept a pair.
- in_a, input, N, multiplicand.
- in_b, input, N, multiplier.
- out_valid, output, 1, product held for the consumer.
- out_ready, input, 1, consumer accepts the product.
- out_p, output, 2N, product.
- mult_start, output, 1, start line to the sequencer.
- mult_a, output, N, multiplicand to the datapath.
- mult_b, output, N, multiplier to the datapath.
- mult_resetout, input, 1, sequencer is in idle (its resetout).
- mult_ready, input, 1, sequencer is in stopped (product valid).
- mult_product, input, 2N, datapath product register.
- busy, output, 1, an operation is in flight (state is not IDLE).

Behaviour:
- One clock domain, clock. Asynchronous active-low reset nreset.
- Reset values: state=IDLE; queue empty; in_ready=1; out_valid=0; out_p=0; mult_start=0; mult_a=0; mult_b=0; busy=0.
- Input handshake:
  - A transfer occurs on a rising edge with in_valid&&in_ready.
  - in_ready = queue not full. It is registered-free, a function of the occupancy count only.
  - Simultaneous push and pop when full is not allowed, because in_ready=0 when full.
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
- Queue:
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - Occupancy counter of width log2(DEPTH)+1.
  - The head entry drives mult_a/mult_b combinationally whenever the queue is non-empty, otherwise 0.
- State machine:
  - IDLE: if the queue is non-empty and mult_resetout=1 and out_valid=0, go to RUN. Otherwise stay. mult_start=0.
  - RUN: mult_start=1. Operands are held stable from the head entry, which is not popped. If mult_ready=1, go to CAPTURE.
  - CAPTURE: mult_start=1, so the sequencer stays in stopped. out_p<=mult_product; out_valid<=1; pop the head; go to RELEASE.
  - RELEASE: mult_start=0. Wait for mult_resetout=1, then go to IDLE.
- Output handshake:
  - out_valid clears on the edge where out_valid&&out_ready.
  - out_p holds its value until the next capture.
  - IDLE will not launch while out_valid=1. This gives a single result slot and guarantees no overwrite.
  - A launch may occur in the same cycle out_valid clears only if out_ready is sampled high in that cycle. The transition to RUN is allowed that cycle.
- Latency:
  - Empty block, in_valid at edge k: RUN from k+1. The result then appears 1 cycle after mult_ready is first seen high.
  - For N=8 the sequencer gives 8 adding cycles, so out_valid rises roughly 11 cycles after acceptance.
- Back-to-back throughput: one product per (sequencer latency + 3) cycles.
- Reset mid-operation: all state returns to reset values immediately. Queued operands and any pending result are discarded. mult_start drops asynchronously, which forces the sequencer to idle on its next clock.
- Width rule: out_p is captured from mult_product with no truncation. Operands are unsigned.

Optional Feature:
- Macro: ISSUE_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in RUN, cleared on entry to RUN.
  - If it reaches TIMEOUT without mult_ready, go to RELEASE and pop the head.
  - Set a sticky output timeout_err=1, cleared only by nreset.
  - No product is captured and out_valid stays 0.
- When undefined:
  - No counter and no timeout_err port.
  - RUN waits indefinitely for mult_ready.

Test Plan:
- Single op, N=8, in_a=13, in_b=11 -> out_valid=1 with out_p=16'h008F; mult_start low for at least 1 cycle afterwards; busy=0 at the end.
- Max operands 255*255 -> out_p=16'hFE01; no truncation.
- Three pairs pushed back-to-back: (2,3),(4,5),(6,7):
  - in_ready=0 after two accepts until the first pop.
  - Results 6, 20, 42 appear in order.
- Backpressure with out_ready=0 for 30 cycles after the first result:
  - out_p stays 6.
  - Second op is not launched (mult_start=0, state IDLE).
  - Second op launches after out_ready=1.
- nreset asserted while in RUN:
  - Immediately mult_start=0, out_valid=0, in_ready=1, queue empty.
  - After release, a new op (9,9) gives 81.
- With ISSUE_TIMEOUT_EN and mult_ready tied 0, TIMEOUT=64:
  - timeout_err=1 after 64 RUN cycles.
  - Head is popped and out_valid stays 0.

Source files
------------

// File: rtl/mult_issue.sv
// mult_issue: operand queue and start sequencing for the shift-add multiplier.
// Optional RUN watchdog with sticky timeout_err when ISSUE_TIMEOUT_EN is defined.
module mult_issue #(
   parameter int N       = 8,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic           clock,
   input  logic           nreset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_p,
   output logic           mult_start,
   output logic [N-1:0]   mult_a,
   output logic [N-1:0]   mult_b,
   input  logic           mult_resetout,
   input  logic           mult_ready,
   input  logic [2*N-1:0] mult_product,
`ifdef ISSUE_TIMEOUT_EN
   output logic           timeout_err,
`endif
   output logic           busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, RUN, CAPTURE, RELEASE} state_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TW < 1)
      $error("mult_issue: bad parameters");

   state_t        state, state_nx;
   logic [N-1:0]  mem_a [DEPTH];
   logic [N-1:0]  mem_b [DEPTH];
   logic [AW-1:0] rptr, wptr;
   logic [AW:0]   count;
   logic          push, pop, empty, launch, capture;

   assign empty    = (count == '0);
   assign in_ready = (count != (AW+1)'(DEPTH));
   assign push     = in_valid && in_ready;
   assign mult_a   = empty ? '0 : mem_a[rptr];
   assign mult_b   = empty ? '0 : mem_b[rptr];
   assign busy     = (state != IDLE);
   // a draining result frees the slot on this same edge
   assign launch   = !empty && mult_resetout && (!out_valid || out_ready);

`ifdef ISSUE_TIMEOUT_EN
   logic [TW-1:0] tcnt;
   logic          tmo;
   assign tmo = (state == RUN) && !mult_ready && (tcnt == TW'(TIMEOUT - 1));
`endif

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      mult_start = 1'b0;
      pop        = 1'b0;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            if (launch) state_nx = RUN;
         end
         RUN: begin
            mult_start = 1'b1;
            if (mult_ready) state_nx = CAPTURE;
`ifdef ISSUE_TIMEOUT_EN
            else if (tmo) begin
               state_nx = RELEASE;
               pop      = 1'b1;
            end
`endif
         end
         CAPTURE: begin
            mult_start = 1'b1;
            pop        = 1'b1;
            capture    = 1'b1;
            state_nx   = RELEASE;
         end
         RELEASE: begin
            if (mult_resetout) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_a[wptr] <= in_a;
         mem_b[wptr] <= in_b;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         out_valid <= 1'b0;
         out_p     <= '0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_p     <= mult_product;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ISSUE_TIMEOUT_EN
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         tcnt        <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != RUN && state_nx == RUN) tcnt <= '0;
         else if (state == RUN)              tcnt <= tcnt + TW'(1);
         if (tmo) timeout_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mult_issue.sv
// tb_mult_issue: sequencer/datapath stand-in, queue-level reference model,
// directed literal checks and a randomized traffic phase.
module tb_mult_issue;
   localparam int N     = 8;
   localparam int DEPTH = 2;

   logic          clock = 1'b0;
   logic          nreset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_a = '0;
   logic [N-1:0]  in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_p;
   logic          mult_start;
   logic [N-1:0]  mult_a, mult_b;
   logic          mult_resetout, mult_ready;
   logic [15:0]   mult_product;
   logic          busy;
`ifdef ISSUE_TIMEOUT_EN
   logic          timeout_err;
`endif

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   mult_issue #(.N(N), .DEPTH(DEPTH), .TIMEOUT(64)) dut (
      .clock(clock), .nreset(nreset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_resetout(mult_resetout), .mult_ready(mult_ready),
      .mult_product(mult_product),
`ifdef ISSUE_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .busy(busy)
   );

   // sequencer stand-in: idle -> N adding cycles -> stopped, back to idle when start drops
   typedef enum {S_IDLE, S_ADD, S_STOP} seq_t;
   seq_t        seq = S_IDLE;
   int          sc = 0;
   logic        stall = 1'b0;
   logic [15:0] prod_r = '0;

   always @(posedge clock) begin
      case (seq)
         S_IDLE: if (mult_start) begin seq <= S_ADD; sc <= 0; end
         S_ADD: begin
            if (!mult_start) seq <= S_IDLE;
            else if (sc == N - 1) begin
               seq    <= S_STOP;
               prod_r <= 16'(mult_a) * 16'(mult_b);
            end else sc <= sc + 1;
         end
         default: if (!mult_start) seq <= S_IDLE;
      endcase
   end

   assign mult_resetout = (seq == S_IDLE);
   assign mult_ready    = (seq == S_STOP) && !stall;
   assign mult_product  = prod_r;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: pending operand queue, single result slot
   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   logic [15:0] last_p = '0;
   logic        chk_en = 1'b1;
   logic        s_rst, s_in, s_out, s_ov;
   logic [7:0]  s_a, s_b;

   always begin
      @(negedge clock);
      s_rst = !nreset;
      s_in  = in_valid && in_ready;
      s_out = out_valid && out_ready;
      s_ov  = out_valid;
      s_a   = in_a;
      s_b   = in_b;
      @(posedge clock);
      #1;
      if (s_rst || !nreset) begin
         qa.delete();
         qb.delete();
         last_p = '0;
      end else if (chk_en) begin
         if (s_in) begin
            qa.push_back(s_a);
            qb.push_back(s_b);
         end
         if (out_valid && !s_ov) begin
            if (qa.size() == 0) chk("spurious_result", 1, 0);
            else begin
               last_p = 16'(qa[0]) * 16'(qb[0]);
               void'(qa.pop_front());
               void'(qb.pop_front());
            end
         end else begin
            if (s_ov && !s_out) chk("hold_valid", out_valid, 1);
            if (s_out)          chk("clear_valid", out_valid, 0);
         end
         chk("out_p", out_p, last_p);
         chk("in_ready", in_ready, qa.size() < DEPTH);
         if (qa.size() > 0) begin
            chk("mult_a", mult_a, qa[0]);
            chk("mult_b", mult_b, qb[0]);
         end else begin
            chk("mult_a_empty", mult_a, 0);
            chk("mult_start_empty", mult_start, 0);
         end
         if (mult_start) chk("busy_run", busy, 1);
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      logic ok;
      int   n;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      n        = 0;
      do begin
         @(negedge clock);
         ok = in_ready;
         step();
         n++;
      end while (!ok && n < 300);
      in_valid = 1'b0;
      if (!ok) chk("push_wait", 0, 1);
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!out_valid && n < 200);
      if (!out_valid) chk("valid_wait", 0, 1);
   endtask

   task automatic get_result(output logic [15:0] r);
      wait_valid();
      r = out_p;
      step();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      chk("idle_wait", busy, 0);
   endtask

   logic [15:0] r;
   logic        prod_done = 1'b0;

   initial begin
      #500000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clock);
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_start", mult_start, 0);
      chk("rst_mult_a", mult_a, 0);
      chk("rst_busy", busy, 0);
      nreset    = 1'b1;
      out_ready = 1'b1;
      step();

      push(13, 11);
      get_result(r);
      chk("p_13x11", r, 16'h008F);
      step();
      chk("start_low_after", mult_start, 0);
      wait_idle();

      push(255, 255);
      get_result(r);
      chk("p_255x255", r, 16'hFE01);
      wait_idle();

      out_ready = 1'b0;
      push(2, 3);
      push(4, 5);
      chk("full_in_ready", in_ready, 0);
      push(6, 7);
      wait_valid();
      chk("first_p", out_p, 6);
      repeat (3) step();
      for (int i = 0; i < 27; i++) begin
         step();
         chk("bp_start", mult_start, 0);
         chk("bp_busy", busy, 0);
         chk("bp_p", out_p, 6);
      end
      out_ready = 1'b1;
      step();
      get_result(r);
      chk("second_p", r, 20);
      get_result(r);
      chk("third_p", r, 42);
      wait_idle();

      push(5, 7);
      for (int i = 0; i < 20 && !mult_start; i++) step();
      step();
      step();
      chk("pre_rst_start", mult_start, 1);
      #1 nreset = 1'b0;
      #1;
      chk("mid_rst_start", mult_start, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mult_a", mult_a, 0);
      step();
      nreset = 1'b1;
      step();
      push(9, 9);
      get_result(r);
      chk("p_9x9", r, 81);
      wait_idle();

      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 3)) step();
               if (i % 10 == 0) push(8'hFF, 8'(i));
               else push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            prod_done = 1'b1;
         end
         begin
            while (!prod_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               step();
            end
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 300 && (qa.size() != 0 || out_valid); i++) step();
      chk("drain", qa.size() == 0 && !out_valid, 1);
      wait_idle();

`ifdef ISSUE_TIMEOUT_EN
      begin
         int runs = 0;
         chk_en = 1'b0;
         nreset = 1'b0;
         step();
         nreset = 1'b1;
         stall  = 1'b1;
         step();
         push(1, 1);
         for (int i = 0; i < 200 && !timeout_err; i++) begin
            @(negedge clock);
            if (mult_start) runs++;
         end
         chk("timeout_err", timeout_err, 1);
         chk("timeout_runs", runs, 64);
         chk("timeout_valid", out_valid, 0);
         wait_idle();
         stall = 1'b0;
         chk("timeout_pop", in_ready, 1);
         chk("timeout_pop_a", mult_a, 0);
         chk("timeout_sticky", timeout_err, 1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
